// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared pipeline defaults and the mult/div tracker state type.
package mips_pipe_pkg;
  localparam int REG_W_DEF = 5;
  localparam int MD_LAT_DEF = 8;
  typedef enum logic {RUN, MD_BUSY} md_state_e;
endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker: mult/div occupancy countdown; frozen while advance is low.
module md_busy_tracker
  import mips_pipe_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic advance,
  output logic busy
);
  md_state_e state, state_nx;
  logic [7:0] cnt, cnt_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (advance && state == RUN && start) begin
      state_nx = MD_BUSY;
      cnt_nx = 8'(MD_LAT - 1);
    end else if (advance && state == MD_BUSY) begin
      state_nx = cnt == '0 ? RUN : MD_BUSY;
      cnt_nx = cnt == '0 ? cnt : cnt - 8'd1;
    end
  end
  assign busy = state == MD_BUSY;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush decode with mult/div occupancy and stall counter.
module hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_uses_md,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_md_start,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             cu_mux_sel,
  output logic             pipe_hold,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);
  logic load_use, md_hazard, flush, stall;
  md_busy_tracker #(.MD_LAT(MD_LAT)) u_md (
    .clk(clk),
    .rst(rst),
    .start(ex_md_start),
    .advance(~mem_busy),
    .busy(md_busy)
  );
  assign load_use = ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign md_hazard = id_uses_md & md_busy;
  // Reset looks like a permanent flush so nothing leaks into the pipe.
  always_comb begin
    flush = rst | (~mem_busy & ex_branch_taken);
    stall = ~rst & ~mem_busy & ~ex_branch_taken & (md_hazard | load_use);
    pc_write = ~rst & ~mem_busy & ~stall;
    ifid_write = ~rst & ~mem_busy & ~stall;
    ifid_flush = flush;
    cu_mux_sel = flush | stall;
    pipe_hold = ~rst & mem_busy;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if ((cu_mux_sel | pipe_hold) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl stall, flush, mult/div and reset behaviour.
module tb_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
  logic id_uses_rt = 0, id_uses_md = 0, ex_mem_read = 0, ex_md_start = 0, ex_branch_taken = 0, mem_busy = 0;
  logic pc_write, ifid_write, ifid_flush, cu_mux_sel, pipe_hold, md_busy;
  logic [15:0] stall_cnt;
  logic pc_write2, ifid_write2, ifid_flush2, cu_mux_sel2, pipe_hold2, md_busy2;
  logic [1:0] stall_cnt2;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_uses_md(id_uses_md),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .cu_mux_sel(cu_mux_sel), .pipe_hold(pipe_hold), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );
  hazard_ctrl #(.MD_LAT(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_uses_md(id_uses_md),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
    .cu_mux_sel(cu_mux_sel2), .pipe_hold(pipe_hold2), .md_busy(md_busy2), .stall_cnt(stall_cnt2)
  );
  wire [5:0] outs = {pc_write, ifid_write, ifid_flush, cu_mux_sel, pipe_hold, md_busy};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_uses_md = 0;
    ex_mem_read = 0; ex_md_start = 0; ex_branch_taken = 0; mem_busy = 0;
  endtask
  initial begin
    #2;
    chk("reset_outs", 32'(outs), 32'b001100);
    chk("reset_cnt", 32'(stall_cnt), 0);
    tick; tick;
    rst = 0;
    #1;
    chk("idle_outs", 32'(outs), 32'b110000);
    chk("idle_cnt", 32'(stall_cnt), 0);
    tick;
    ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    #1 chk("load_use", 32'(outs), 32'b000100);
    tick; clr;
    #1 chk("load_use_done", 32'(outs), 32'b110000);
    chk("load_use_cnt", 32'(stall_cnt), 1);
    chk("load_use_cnt2", 32'(stall_cnt2), 1);
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    #1 chk("rt_zero", 32'(outs), 32'b110000);
    ex_rt = 7; id_rt = 7; id_uses_rt = 0;
    #1 chk("rt_unused", 32'(outs), 32'b110000);
    id_uses_rt = 1;
    #1 chk("rt_used", 32'(outs), 32'b000100);
    tick; clr;
    #1 chk("rt_cnt", 32'(stall_cnt), 2);
    tick;
    ex_md_start = 1;
    #1 chk("md_start", 32'(outs), 32'b110000);
    tick;
    for (int k = 1; k <= 8; k++) begin
      ex_md_start = k >= 2 && k <= 7;
      id_uses_md = 1;
      #1 chk($sformatf("md_stall_%0d", k), 32'(outs), 32'b000101);
      tick;
    end
    ex_md_start = 0;
    #1 chk("md_issue", 32'(outs), 32'b110000);
    chk("md_cnt", 32'(stall_cnt), 10);
    tick; clr;
    ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3;
    #1 chk("branch_squash", 32'(outs), 32'b111100);
    tick; clr;
    #1 chk("branch_cnt", 32'(stall_cnt), 11);
    ex_md_start = 1;
    tick;
    for (int k = 1; k <= 12; k++) begin
      ex_md_start = 0;
      mem_busy = k >= 3 && k <= 5;
      #1 chk($sformatf("md_mem_%0d", k), 32'(outs), mem_busy ? 32'b000011 : {26'd0, 5'b11000, k <= 11});
      tick;
    end
    clr;
    #1 chk("mem_cnt", 32'(stall_cnt), 14);
    chk("sat_cnt2", 32'(stall_cnt2), 3);
    ex_md_start = 1;
    tick; clr;
    #1 chk("pre_rst_busy", 32'(outs), 32'b110001);
    tick;
    rst = 1;
    #1 chk("rst_outs", 32'(outs), 32'b001100);
    chk("rst_cnt", 32'(stall_cnt), 0);
    tick;
    chk("rst_hold_outs", 32'(outs), 32'b001100);
    rst = 0;
    #1 chk("post_rst", 32'(outs), 32'b110000);
    ex_md_start = 1;
    tick; clr;
    #1 chk("post_rst_md", 32'(outs), 32'b110001);
    chk("post_rst_cnt", 32'(stall_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL have parameter MD_LAT, default 8, multiply/divide latency in cycles (legal range 2..255).
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port id_rs, id_rt  input  REG_W each  source registers of the instruction in ID.
REQ-007 SHALL have port id_uses_rt  input  1  the ID instruction reads rt.
REQ-008 SHALL have port id_uses_md  input  1  the ID instruction is mfhi/mflo/mult/div.
REQ-009 SHALL have port ex_mem_read, ex_rt  input  1, REG_W  the EX instruction is a load, and its destination.
REQ-010 SHALL have port ex_md_start  input  1  mult/div enters EX this cycle.
REQ-011 SHALL have port ex_branch_taken  input  1  branch resolved taken in EX.
REQ-012 SHALL have port mem_busy  input  1  data memory not ready.
REQ-013 SHALL have port pc_write, ifid_write  output  1 each  PC and IF/ID register enables.
REQ-014 SHALL have port ifid_flush  output  1  zero IF/ID.
REQ-015 SHALL have port cu_mux_sel  output  1  1 = control-unit mux selects all-zero controls (bubble into ID/EX).
REQ-016 SHALL have port pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB.
REQ-017 SHALL have port md_busy  output  1  multi-cycle unit occupied.
REQ-018 SHALL have port stall_cnt  output  CNT_W  count of bubble/hold cycles.

Function
REQ-019 SHALL compute outputs combinationally from the current state and current inputs, so a stall takes effect in the same cycle; the default is pc_write=1, ifid_write=1, and all other 1-bit outputs 0.
REQ-020 SHALL define load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
REQ-021 SHALL define md_hazard = id_uses_md & md_busy.
REQ-022 SHALL resolve conditions in priority order mem_busy > ex_branch_taken > md_hazard > load_use.
REQ-023 SHALL, on mem_busy, drive pipe_hold=1, pc_write=0 and ifid_write=0; the FSM and md counter SHALL NOT advance.
REQ-024 SHALL, on ex_branch_taken, drive ifid_flush=1, cu_mux_sel=1 and pc_write=1; any concurrent hazard is squashed.
REQ-025 SHALL, on md_hazard or load_use, drive pc_write=0, ifid_write=0 and cu_mux_sel=1.
REQ-026 SHALL implement FSM states RUN and MD_BUSY, with md_busy=1 exactly in MD_BUSY.
REQ-027 SHALL, on RUN with ex_md_start and no mem_busy, move to MD_BUSY and load the counter with MD_LAT-1.
REQ-028 SHALL, in MD_BUSY with no mem_busy, decrement the counter each cycle and return to RUN when the counter is 0 at the clock edge.
REQ-029 SHALL ignore ex_md_start in MD_BUSY; it cannot occur legally because md_hazard stalls it.
REQ-030 SHALL let ex_branch_taken flush while in MD_BUSY without cancelling the count, because the mult/div was already committed.
REQ-031 SHALL increment stall_cnt by 1 each cycle in which cu_mux_sel|pipe_hold is 1, saturating at all-ones.

Reset
REQ-032 SHALL, while rst=1, force state=RUN, counter=0, stall_cnt=0, md_busy=0, pc_write=0, ifid_write=0, ifid_flush=1, cu_mux_sel=1 and pipe_hold=0.
REQ-033 SHALL, on rst asserted mid-MD_BUSY, abandon the count immediately; after release, the block starts in RUN with md_busy=0.

Structure
REQ-034 SHALL place the state enum (RUN, MD_BUSY), the REG_W default and the MD_LAT default in shared package mips_pipe_pkg.
REQ-035 SHALL implement the countdown and state in one sub-module, md_busy_tracker (inputs start, advance; outputs busy); the priority decode stays in hazard_ctrl.

Verification
REQ-036 SHALL verify: ex_mem_read=1, ex_rt=5, id_rs=5 -> exactly one cycle of pc_write=0, ifid_write=0, cu_mux_sel=1; stall_cnt=1.
REQ-037 SHALL verify: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall; likewise ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-038 SHALL verify: ex_md_start at cycle 0 with MD_LAT=8, then id_uses_md held -> md_busy=1 for cycles 1..8 and stall cycles 1..8; the ID instruction issues in cycle 9.
REQ-039 SHALL verify: ex_branch_taken and load_use in the same cycle -> ifid_flush=1, cu_mux_sel=1, pc_write=1.
REQ-040 SHALL verify: mem_busy held 3 cycles during MD_BUSY -> pipe_hold=1 for 3 cycles, and md_busy is extended by exactly 3 cycles.
REQ-041 SHALL verify: rst pulsed in MD_BUSY -> md_busy=0, stall_cnt=0 and ifid_flush=1 while rst=1; normal RUN behaviour on the first edge after release.
